vx_warp_regfile: RTL and testbench

//   Per-thread 32x32-bit integer register file for one warp lane of the Vortex pipeline.
//   One instance per thread: the thread-0 "master" exports its full register image,
//   and the "slave" copies (threads 1..NT-1) can bulk-load that image on a clone command.

---
 rtl/vx_warp_regfile.sv | 50 +++++
 tb/tb_vx_warp_regfile.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/vx_warp_regfile.sv
// vx_warp_regfile: per-thread 32x32 integer register file with clone bulk-load (slave) and
// optional write-through read bypass enabled by VX_RF_BYPASS_EN.
module vx_warp_regfile #(
   parameter logic WARP_ID  = 1'b0,
   parameter bit   IS_SLAVE = 1'b0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_warp,
   input  logic          in_wb_warp,
   input  logic          in_valid,
   input  logic          in_write_register,
   input  logic [4:0]    in_rd,
   input  logic [31:0]   in_data,
   input  logic [4:0]    in_src1,
   input  logic [4:0]    in_src2,
   input  logic          in_clone,
   input  logic          in_to_clone,
   input  logic [1023:0] in_regs,
   output logic [1023:0] out_regs,
   output logic [31:0]   out_src1_data,
   output logic [31:0]   out_src2_data
);
   logic [31:0][31:0] r_regs;
   logic              w_clone;
   logic              w_write;

   assign w_clone = IS_SLAVE && in_clone && in_to_clone && (in_warp == WARP_ID);
   // a clone overrides any same-cycle writeback, so the write is dropped here
   assign w_write = in_write_register && in_valid && (in_wb_warp == WARP_ID)
                    && (in_rd != 5'd0) && !w_clone;

   always_ff @(posedge clk or posedge reset)
      if (reset)
         r_regs <= '0;
      else if (w_clone)
         for (int i = 1; i < 32; i++) r_regs[i] <= in_regs[32*i +: 32];
      else if (w_write)
         r_regs[in_rd] <= in_data;

   assign out_regs = {r_regs[31:1], 32'h0};

`ifdef VX_RF_BYPASS_EN
   assign out_src1_data = (w_write && in_src1 == in_rd) ? in_data : r_regs[in_src1];
   assign out_src2_data = (w_write && in_src2 == in_rd) ? in_data : r_regs[in_src2];
`else
   assign out_src1_data = r_regs[in_src1];
   assign out_src2_data = r_regs[in_src2];
`endif
endmodule

// File: tb/tb_vx_warp_regfile.sv
// tb_vx_warp_regfile: directed checks of a master (warp 0) and a slave (warp 1) bank sharing stimulus.
module tb_vx_warp_regfile;
   logic          clk = 1'b0;
   logic          reset;
   logic          in_warp, in_wb_warp, in_valid, in_write_register, in_clone, in_to_clone;
   logic [4:0]    in_rd, in_src1, in_src2;
   logic [31:0]   in_data;
   logic [1023:0] in_regs;
   logic [1023:0] regs_m, regs_s;
   logic [31:0]   s1_m, s2_m, s1_s, s2_s;
   logic [31:0]   exp_m [32];
   logic [31:0]   exp_s [32];
   int            vectors = 0;
   int            errs = 0;

   always #5 clk = ~clk;

   vx_warp_regfile #(.WARP_ID(1'b0), .IS_SLAVE(1'b0)) u_m (
      .clk(clk), .reset(reset), .in_warp(in_warp), .in_wb_warp(in_wb_warp), .in_valid(in_valid),
      .in_write_register(in_write_register), .in_rd(in_rd), .in_data(in_data),
      .in_src1(in_src1), .in_src2(in_src2), .in_clone(in_clone), .in_to_clone(in_to_clone),
      .in_regs(in_regs), .out_regs(regs_m), .out_src1_data(s1_m), .out_src2_data(s2_m));

   vx_warp_regfile #(.WARP_ID(1'b1), .IS_SLAVE(1'b1)) u_s (
      .clk(clk), .reset(reset), .in_warp(in_warp), .in_wb_warp(in_wb_warp), .in_valid(in_valid),
      .in_write_register(in_write_register), .in_rd(in_rd), .in_data(in_data),
      .in_src1(in_src1), .in_src2(in_src2), .in_clone(in_clone), .in_to_clone(in_to_clone),
      .in_regs(in_regs), .out_regs(regs_s), .out_src1_data(s1_s), .out_src2_data(s2_s));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      in_write_register = 1'b0; in_valid = 1'b0; in_clone = 1'b0; in_to_clone = 1'b0;
      in_warp = 1'b0; in_wb_warp = 1'b0; in_rd = 5'd0; in_data = 32'h0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin exp_m[i] = 32'h0; exp_s[i] = 32'h0; end
   endtask

   // reference behaviour for one clock edge, then advance past it
   task automatic tick();
      logic wr_m, wr_s, cl_s;
      cl_s = in_clone && in_to_clone && in_warp == 1'b1;
      wr_m = in_write_register && in_valid && in_wb_warp == 1'b0 && in_rd != 5'd0;
      wr_s = in_write_register && in_valid && in_wb_warp == 1'b1 && in_rd != 5'd0;
      if (wr_m) exp_m[in_rd] = in_data;
      if (cl_s) for (int i = 1; i < 32; i++) exp_s[i] = in_regs[32*i +: 32];
      else if (wr_s) exp_s[in_rd] = in_data;
      @(posedge clk);
      #1;
   endtask

   task automatic check_bank(input string tag);
      idle();
      for (int i = 0; i < 32; i++) begin
         in_src1 = 5'(i);
         in_src2 = 5'(31 - i);
         #1;
         chk({tag, "_m_src1"}, s1_m, exp_m[i]);
         chk({tag, "_m_src2"}, s2_m, exp_m[31-i]);
         chk({tag, "_s_src1"}, s1_s, exp_s[i]);
         chk({tag, "_s_src2"}, s2_s, exp_s[31-i]);
         chk({tag, "_m_regs"}, regs_m[32*i +: 32], exp_m[i]);
         chk({tag, "_s_regs"}, regs_s[32*i +: 32], exp_s[i]);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      reset = 1'b1; in_src1 = 5'd0; in_src2 = 5'd0; in_regs = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check_bank("reset");
      // write rd=5 on master, different value into slave rd=5
      in_write_register = 1'b1; in_valid = 1'b1; in_wb_warp = 1'b0; in_rd = 5'd5; in_data = 32'hDEADBEEF;
      tick();
      in_wb_warp = 1'b1; in_data = 32'h00C0FFEE;
      tick();
      idle(); in_src1 = 5'd5; #1;
      chk("wr5_m_src1", s1_m, 32'hDEADBEEF);
      chk("wr5_m_regs", regs_m[191:160], 32'hDEADBEEF);
      chk("wr5_s_src1", s1_s, 32'h00C0FFEE);
      // rd=0 discarded, valid=0 ignored, wrong warp ignored
      in_write_register = 1'b1; in_valid = 1'b1; in_wb_warp = 1'b0; in_rd = 5'd0; in_data = 32'h1234;
      tick();
      in_valid = 1'b0; in_rd = 5'd5; in_data = 32'h1111;
      tick();
      in_valid = 1'b1; in_wb_warp = 1'b1; in_data = 32'h2222;
      tick();
      idle(); in_src1 = 5'd0; in_src2 = 5'd5; #1;
      chk("x0_m_src1", s1_m, 32'h0);
      chk("x0_m_regs", regs_m[31:0], 32'h0);
      chk("keep5_m", s2_m, 32'hDEADBEEF);
      chk("warp5_s", s2_s, 32'h2222);
      check_bank("writes");
      // clone image reg i = i*3, first with to_clone=0, then master-warp clone, then real clone
      for (int i = 0; i < 32; i++) in_regs[32*i +: 32] = 32'(i * 3);
      in_clone = 1'b1; in_to_clone = 1'b0; in_warp = 1'b1;
      tick();
      idle(); in_src1 = 5'd7; #1;
      chk("noclone_s7", s1_s, 32'h0);
      in_clone = 1'b1; in_to_clone = 1'b1; in_warp = 1'b0;
      tick();
      idle(); #1;
      chk("master_ignores_clone", s1_m, 32'h0);
      chk("wrongwarp_s7", s1_s, 32'h0);
      in_clone = 1'b1; in_to_clone = 1'b1; in_warp = 1'b1;
      tick();
      idle(); in_src1 = 5'd7; in_src2 = 5'd0; #1;
      chk("clone_s7", s1_s, 32'd21);
      chk("clone_s0", s2_s, 32'h0);
      chk("clone_s5", regs_s[191:160], 32'd15);
      check_bank("clone");
      // clone and write in the same cycle: clone wins
      in_clone = 1'b1; in_to_clone = 1'b1; in_warp = 1'b1;
      in_write_register = 1'b1; in_valid = 1'b1; in_wb_warp = 1'b1; in_rd = 5'd7; in_data = 32'hFF;
      in_src1 = 5'd7; #1;
      chk("clonewr_pre_s7", s1_s, 32'd21);
      tick();
      idle(); #1;
      chk("clonewr_s7", s1_s, 32'd21);
      // same-cycle read of a written register
      in_write_register = 1'b1; in_valid = 1'b1; in_wb_warp = 1'b0; in_rd = 5'd9; in_data = 32'hA5A5A5A5;
      in_src2 = 5'd9; #1;
`ifdef VX_RF_BYPASS_EN
      chk("bypass_m9", s2_m, 32'hA5A5A5A5);
`else
      chk("nobypass_m9", s2_m, 32'h0);
`endif
      chk("bypass_other_s9", s2_s, 32'd27);
      tick();
      idle(); #1;
      chk("after_m9", s2_m, 32'hA5A5A5A5);
      // async reset during a pending write, held across the edge
      in_write_register = 1'b1; in_valid = 1'b1; in_wb_warp = 1'b0; in_rd = 5'd9; in_data = 32'h5;
      #1 reset = 1'b1;
      #1;
      model_reset();
      chk("async_m9", regs_m[319:288], 32'h0);
      chk("async_s7", regs_s[255:224], 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      check_bank("postreset");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
